uart_tx_tick: RTL and testbench

UART_TX_TICK -- requirements
Module: uart_tx_tick

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_bit_timer.sv | 18 +
 rtl/uart_tx_tick.sv | 80 ++++++++
 tb/tb_uart_tx_tick.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter state encoding and default framing constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;
    localparam int DEF_TICKS_PER_BIT = 8;
    localparam int DEF_STOP_BITS = 1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts enable ticks within one serial bit and flags the last tick
module uart_bit_timer #(
    parameter int TICKS_PER_BIT = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClear,
    input  logic iEnable,
    output logic oTerminal
);
    localparam int W = $clog2(TICKS_PER_BIT);
    logic [W-1:0] tickCnt;
    always_comb oTerminal = iEnable && (tickCnt == W'(TICKS_PER_BIT - 1));
    always_ff @(posedge iClk) begin
        if (iRst || iClear) tickCnt <= '0;
        else if (iEnable) tickCnt <= oTerminal ? '0 : tickCnt + W'(1);
    end
endmodule

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: 8N1/8N2 UART transmitter paced by an external tick enable
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEnable,
    input  logic       iValid,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oTxd,
    output logic       oBusy,
    output logic       oDone
);
    txState_t state;
    logic [7:0] shiftReg;
    logic [2:0] bitIdx;
    logic bitEnd;
    // Holding the timer clear while idle also drops a tick coincident with accept
    uart_bit_timer #(.TICKS_PER_BIT(TICKS_PER_BIT)) timer (
        .iClk(iClk),
        .iRst(iRst),
        .iClear(state == IDLE),
        .iEnable(iEnable),
        .oTerminal(bitEnd)
    );
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            shiftReg <= '0;
            bitIdx <= '0;
            oTxd <= 1'b1;
            oReady <= 1'b1;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: if (iValid) begin
                    state <= START;
                    shiftReg <= iData;
                    bitIdx <= '0;
                    oTxd <= 1'b0;
                    oReady <= 1'b0;
                    oBusy <= 1'b1;
                end
                START: if (bitEnd) begin
                    state <= DATA;
                    oTxd <= shiftReg[0];
                end
                DATA: if (bitEnd) begin
                    shiftReg <= shiftReg >> 1;
                    if (bitIdx == 3'd7) begin
                        state <= STOP;
                        oTxd <= 1'b1;
                        bitIdx <= '0;
                    end else begin
                        bitIdx <= bitIdx + 3'd1;
                        oTxd <= shiftReg[1];
                    end
                end
                STOP: if (bitEnd) begin
                    if (bitIdx == 3'(STOP_BITS - 1)) begin
                        state <= IDLE;
                        bitIdx <= '0;
                        oReady <= 1'b1;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        bitIdx <= bitIdx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_tick.sv
// tb_uart_tx_tick: randomized scoreboard bench with a per-tick frame model of the line
module tb_uart_tx_tick;
    localparam int TPB = 4;
    localparam int SB = 2;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic iEnable = 1'b0;
    logic iValid = 1'b0;
    logic [7:0] iData = 8'h00;
    logic oReady, oTxd, oBusy, oDone;
    int tests = 0;
    int fails = 0;
    int enMode = 2;
    int enPhase = 0;
    logic [7:0] expQ[$];
    logic frame[$];
    int mTk = 0;
    logic [3:0] expVec = 4'b1100;
    logic mDone;

    always #5 iClk = ~iClk;

    uart_tx_tick #(.TICKS_PER_BIT(TPB), .STOP_BITS(SB)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iEnable(iEnable),
        .iValid(iValid),
        .iData(iData),
        .oReady(oReady),
        .oTxd(oTxd),
        .oBusy(oBusy),
        .oDone(oDone)
    );

    always @(negedge iClk) begin
        enPhase = enPhase + 1;
        iEnable = (enMode == 0) ? 1'($urandom_range(0, 1)) :
                  (enMode == 1) ? 1'(enPhase % 2) : (enMode == 2);
    end

    // Reference: a frame is a list of line levels, each held for TPB counted ticks
    always @(posedge iClk) begin
        mDone = 1'b0;
        if (iRst) begin
            frame.delete();
            expQ.delete();
            mTk = 0;
        end else if (frame.size() == 0) begin
            if (iValid) begin
                frame.push_back(1'b0);
                for (int i = 0; i < 8; i++) frame.push_back(iData[i]);
                for (int i = 0; i < SB; i++) frame.push_back(1'b1);
                mTk = 0;
                expQ.push_back(iData);
            end
        end else if (iEnable) begin
            mTk = mTk + 1;
            if (mTk == TPB) begin
                mTk = 0;
                void'(frame.pop_front());
                mDone = (frame.size() == 0);
            end
        end
        expVec = {(frame.size() == 0) ? 1'b1 : frame[0], frame.size() == 0, frame.size() != 0, mDone};
    end

    initial begin : monitor
        logic prevBusy, enS;
        logic [7:0] dec, e;
        int tk;
        prevBusy = 1'b0;
        dec = 8'h00;
        tk = 0;
        forever begin
            @(posedge iClk);
            enS = iEnable;
            #1;
            tests++;
            if ({oTxd, oReady, oBusy, oDone} !== expVec) begin
                fails++;
                $display("FAIL line t=%0t {txd,ready,busy,done} got %b expected %b", $time,
                         {oTxd, oReady, oBusy, oDone}, expVec);
            end
            if (oBusy && !prevBusy) begin
                tk = 0;
                dec = 8'h00;
            end else if (oBusy && enS) begin
                tk++;
                if (tk % TPB == TPB / 2 && tk / TPB >= 1 && tk / TPB <= 8) dec[tk / TPB - 1] = oTxd;
            end
            if (oDone) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL byte t=%0t oDone with no byte outstanding, decoded %h", $time, dec);
                end else begin
                    e = expQ.pop_front();
                    if (dec !== e) begin
                        fails++;
                        $display("FAIL byte t=%0t decoded %h expected %h", $time, dec, e);
                    end
                end
            end
            prevBusy = oBusy;
        end
    end

    task automatic send(input logic [7:0] b, input bit keep);
        int n = 0;
        @(negedge iClk);
        iValid = 1'b1;
        iData = b;
        while (!oReady && n < 5000) begin
            @(negedge iClk);
            n++;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL accept timeout byte %h oReady %b expected 1", b, oReady);
        end
        @(negedge iClk);
        if (!keep) iValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!oReady && n < 5000) begin
            @(negedge iClk);
            n++;
        end
        tests++;
        if (!oReady) begin
            fails++;
            $display("FAIL idle timeout oReady %b expected 1", oReady);
        end
    endtask

    initial begin
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        enMode = 1;
        send(8'hA5, 0);
        waitIdle();
        enMode = 2;
        send(8'h00, 0);
        waitIdle();
        enMode = 1;
        send(8'h01, 1);
        send(8'hFF, 0);
        waitIdle();
        send(8'hC3, 1);
        repeat (20) @(negedge iClk);
        send(8'h3C, 0);
        waitIdle();
        enMode = 2;
        send(8'hAA, 0);
        repeat (21) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        send(8'h55, 0);
        waitIdle();
        enMode = 0;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 30)) @(negedge iClk);
        end
        iValid = 1'b0;
        waitIdle();
        repeat (5) @(negedge iClk);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain %0d bytes never completed, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
